// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Purpose  : Multicycle control unit. Sequences each instruction through
//            FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK states and drives
//            the datapath enables and mux selects from the registered state.
//            Stalls on the memory-ready handshake; undefined opcodes trap.
// Ports    :
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   i_opcode      opcode field from the IR (sampled only in DECODE)
//   i_mem_ready   memory finished the current read/write this cycle
//   i_alu_zero    ALU zero flag (used by BRANCH)
//   o_pc_en       PC load enable
//   o_ir_write    IR load enable
//   o_iord        memory address select: 0 = PC, 1 = ALU out
//   o_mem_read    memory read request
//   o_mem_write   memory write request
//   o_reg_write   register file write enable
//   o_reg_dst     destination select: 1 = rd, 0 = rt
//   o_mem_to_reg  writeback select: 1 = MDR
//   o_alu_src_a   ALU A select: 0 = PC, 1 = rs
//   o_alu_src_b   ALU B select: 0 rt, 1 const 1, 2 ext imm, 3 branch imm
//   o_ext_op      immediate extension: 1 = sign, 0 = zero
//   o_alu_op      ALU operation class: 0 R, 1 lw, 2 sw, 3 beq, 4 j
//   o_pc_src      next-PC select: 0 ALU, 1 ALU out reg, 2 jump target
//   o_illegal     sticky undefined-opcode flag
//   o_busy        high in every state except RESET and TRAP
// Revision : 1.0  initial release
// ============================================================================
module multicycle_control_fsm #(
   parameter int OP_W     = 4,
   parameter int ALU_OP_W = 3,
   parameter int OP_R     = 0,
   parameter int OP_LW    = 1,
   parameter int OP_SW    = 2,
   parameter int OP_BEQ   = 3,
   parameter int OP_J     = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OP_W-1:0]     i_opcode,
   input  logic                i_mem_ready,
   input  logic                i_alu_zero,
   output logic                o_pc_en,
   output logic                o_ir_write,
   output logic                o_iord,
   output logic                o_mem_read,
   output logic                o_mem_write,
   output logic                o_reg_write,
   output logic                o_reg_dst,
   output logic                o_mem_to_reg,
   output logic                o_alu_src_a,
   output logic [1:0]          o_alu_src_b,
   output logic                o_ext_op,
   output logic [ALU_OP_W-1:0] o_alu_op,
   output logic [1:0]          o_pc_src,
   output logic                o_illegal,
   output logic                o_busy
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [OP_W-1:0] c_OP_R   = OP_W'(OP_R);
   localparam logic [OP_W-1:0] c_OP_LW  = OP_W'(OP_LW);
   localparam logic [OP_W-1:0] c_OP_SW  = OP_W'(OP_SW);
   localparam logic [OP_W-1:0] c_OP_BEQ = OP_W'(OP_BEQ);
   localparam logic [OP_W-1:0] c_OP_J   = OP_W'(OP_J);

   // ALU operation classes, same encoding as the single-cycle decoder
   localparam logic [ALU_OP_W-1:0] c_ALU_R   = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] c_ALU_LW  = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] c_ALU_SW  = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] c_ALU_BEQ = ALU_OP_W'(3);
   localparam logic [ALU_OP_W-1:0] c_ALU_J   = ALU_OP_W'(4);

   localparam logic [1:0] c_SRCB_RT  = 2'd0;
   localparam logic [1:0] c_SRCB_ONE = 2'd1;
   localparam logic [1:0] c_SRCB_IMM = 2'd2;
   localparam logic [1:0] c_SRCB_BR  = 2'd3;

   localparam logic [1:0] c_PC_ALU    = 2'd0;
   localparam logic [1:0] c_PC_ALUOUT = 2'd1;
   localparam logic [1:0] c_PC_JUMP   = 2'd2;

   // State encoding
   localparam logic [3:0] c_ST_RESET    = 4'd0;
   localparam logic [3:0] c_ST_FETCH    = 4'd1;
   localparam logic [3:0] c_ST_DECODE   = 4'd2;
   localparam logic [3:0] c_ST_EXEC_R   = 4'd3;
   localparam logic [3:0] c_ST_R_WB     = 4'd4;
   localparam logic [3:0] c_ST_MEM_ADDR = 4'd5;
   localparam logic [3:0] c_ST_MEM_RD   = 4'd6;
   localparam logic [3:0] c_ST_MEM_WB   = 4'd7;
   localparam logic [3:0] c_ST_MEM_WR   = 4'd8;
   localparam logic [3:0] c_ST_BRANCH   = 4'd9;
   localparam logic [3:0] c_ST_JUMP     = 4'd10;
   localparam logic [3:0] c_ST_TRAP     = 4'd11;

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   logic [3:0] r_state;
   logic [3:0] w_next_state;
   // Remembers whether the memory instruction decoded was a store, so that
   // MEM_ADDR never has to look at the opcode (which may have moved on).
   logic       r_is_store;
   logic       w_is_store_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_ST_RESET;
         r_is_store <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_is_store <= w_is_store_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state    = r_state;
      w_is_store_next = r_is_store;
      case (r_state)
         c_ST_RESET: w_next_state = c_ST_FETCH;
         c_ST_FETCH: begin
            if (i_mem_ready) w_next_state = c_ST_DECODE;
         end
         c_ST_DECODE: begin
            // Priority chain: tolerates parameter sets with aliased opcodes
            if (i_opcode == c_OP_R) begin
               w_next_state = c_ST_EXEC_R;
            end else if (i_opcode == c_OP_LW) begin
               w_next_state    = c_ST_MEM_ADDR;
               w_is_store_next = 1'b0;
            end else if (i_opcode == c_OP_SW) begin
               w_next_state    = c_ST_MEM_ADDR;
               w_is_store_next = 1'b1;
            end else if (i_opcode == c_OP_BEQ) begin
               w_next_state = c_ST_BRANCH;
            end else if (i_opcode == c_OP_J) begin
               w_next_state = c_ST_JUMP;
            end else begin
               w_next_state = c_ST_TRAP;
            end
         end
         c_ST_EXEC_R:   w_next_state = c_ST_R_WB;
         c_ST_R_WB:     w_next_state = c_ST_FETCH;
         c_ST_MEM_ADDR: w_next_state = r_is_store ? c_ST_MEM_WR : c_ST_MEM_RD;
         c_ST_MEM_RD: begin
            if (i_mem_ready) w_next_state = c_ST_MEM_WB;
         end
         c_ST_MEM_WB:   w_next_state = c_ST_FETCH;
         c_ST_MEM_WR: begin
            if (i_mem_ready) w_next_state = c_ST_FETCH;
         end
         c_ST_BRANCH:   w_next_state = c_ST_FETCH;
         c_ST_JUMP:     w_next_state = c_ST_FETCH;
         c_ST_TRAP:     w_next_state = c_ST_TRAP;
         // Unused encodings recover through RESET with all outputs idle
         default:       w_next_state = c_ST_RESET;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output decode (combinational from state, plus mem_ready / alu_zero)
   // ------------------------------------------------------------------------
   logic                w_pc_en;
   logic                w_ir_write;
   logic                w_iord;
   logic                w_mem_read;
   logic                w_mem_write;
   logic                w_reg_write;
   logic                w_reg_dst;
   logic                w_mem_to_reg;
   logic                w_alu_src_a;
   logic [1:0]          w_alu_src_b;
   logic                w_ext_op;
   logic [ALU_OP_W-1:0] w_alu_op;
   logic [1:0]          w_pc_src;

   always_comb begin
      w_pc_en      = 1'b0;
      w_ir_write   = 1'b0;
      w_iord       = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_reg_dst    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = c_SRCB_RT;
      w_ext_op     = 1'b0;
      w_alu_op     = c_ALU_R;
      w_pc_src     = c_PC_ALU;
      case (r_state)
         c_ST_FETCH: begin
            // PC+1 computed alongside the instruction read; both registers
            // only load once memory has actually delivered the word.
            w_mem_read  = 1'b1;
            w_iord      = 1'b0;
            w_alu_src_a = 1'b0;
            w_alu_src_b = c_SRCB_ONE;
            w_alu_op    = c_ALU_R;
            w_pc_src    = c_PC_ALU;
            w_ir_write  = i_mem_ready;
            w_pc_en     = i_mem_ready;
         end
         c_ST_DECODE: begin
            // Speculative branch-target computation into ALU out
            w_alu_src_a = 1'b0;
            w_alu_src_b = c_SRCB_BR;
            w_ext_op    = 1'b1;
         end
         c_ST_EXEC_R: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = c_SRCB_RT;
            w_alu_op    = c_ALU_R;
         end
         c_ST_R_WB: begin
            w_reg_write  = 1'b1;
            w_reg_dst    = 1'b1;
            w_mem_to_reg = 1'b0;
         end
         c_ST_MEM_ADDR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = c_SRCB_IMM;
            w_ext_op    = 1'b1;
            w_alu_op    = r_is_store ? c_ALU_SW : c_ALU_LW;
         end
         c_ST_MEM_RD: begin
            w_mem_read = 1'b1;
            w_iord     = 1'b1;
         end
         c_ST_MEM_WB: begin
            w_reg_write  = 1'b1;
            w_reg_dst    = 1'b0;
            w_mem_to_reg = 1'b1;
         end
         c_ST_MEM_WR: begin
            w_mem_write = 1'b1;
            w_iord      = 1'b1;
         end
         c_ST_BRANCH: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = c_SRCB_RT;
            w_alu_op    = c_ALU_BEQ;
            w_pc_src    = c_PC_ALUOUT;
            w_pc_en     = i_alu_zero;
         end
         c_ST_JUMP: begin
            w_alu_op = c_ALU_J;
            w_pc_src = c_PC_JUMP;
            w_pc_en  = 1'b1;
         end
         default: begin
            // RESET, TRAP and unused encodings keep every control idle
         end
      endcase
   end

   assign o_pc_en      = w_pc_en;
   assign o_ir_write   = w_ir_write;
   assign o_iord       = w_iord;
   assign o_mem_read   = w_mem_read;
   assign o_mem_write  = w_mem_write;
   assign o_reg_write  = w_reg_write;
   assign o_reg_dst    = w_reg_dst;
   assign o_mem_to_reg = w_mem_to_reg;
   assign o_alu_src_a  = w_alu_src_a;
   assign o_alu_src_b  = w_alu_src_b;
   assign o_ext_op     = w_ext_op;
   assign o_alu_op     = w_alu_op;
   assign o_pc_src     = w_pc_src;

   // TRAP is only left through reset, so the flag is sticky by construction
   assign o_illegal = (r_state == c_ST_TRAP);
   assign o_busy    = (r_state != c_ST_RESET) && (r_state != c_ST_TRAP);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_fsm
// Purpose  : Self-checking bench for multicycle_control_fsm. Each instruction
//            is expanded into its list of phases; every cycle the expected
//            control word is derived from the phase and compared with the DUT.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] opcode = 4'd0;
   logic       mem_ready = 1'b1;
   logic       alu_zero = 1'b0;

   logic       o_pc_en, o_ir_write, o_iord, o_mem_read, o_mem_write;
   logic       o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a, o_ext_op;
   logic [1:0] o_alu_src_b, o_pc_src;
   logic [2:0] o_alu_op;
   logic       o_illegal, o_busy;

   always #5 clk = ~clk;

   multicycle_control_fsm dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_opcode     (opcode),
      .i_mem_ready  (mem_ready),
      .i_alu_zero   (alu_zero),
      .o_pc_en      (o_pc_en),
      .o_ir_write   (o_ir_write),
      .o_iord       (o_iord),
      .o_mem_read   (o_mem_read),
      .o_mem_write  (o_mem_write),
      .o_reg_write  (o_reg_write),
      .o_reg_dst    (o_reg_dst),
      .o_mem_to_reg (o_mem_to_reg),
      .o_alu_src_a  (o_alu_src_a),
      .o_alu_src_b  (o_alu_src_b),
      .o_ext_op     (o_ext_op),
      .o_alu_op     (o_alu_op),
      .o_pc_src     (o_pc_src),
      .o_illegal    (o_illegal),
      .o_busy       (o_busy)
   );

   typedef struct packed {
      logic       pc_en;
      logic       ir_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_op;
      logic [2:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal;
      logic       busy;
   } ctrl_t;

   ctrl_t act;
   assign act = {o_pc_en, o_ir_write, o_iord, o_mem_read, o_mem_write,
                 o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a,
                 o_alu_src_b, o_ext_op, o_alu_op, o_pc_src, o_illegal, o_busy};

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected control word for one phase of an instruction
   function automatic ctrl_t expect_ctrl(string ph, logic mr, logic az);
      ctrl_t e;
      e = '0;
      case (ph)
         "FETCH":    begin e.mem_read = 1; e.alu_src_b = 2'd1;
                           e.ir_write = mr; e.pc_en = mr; end
         "DECODE":   begin e.alu_src_b = 2'd3; e.ext_op = 1; end
         "EXEC_R":   begin e.alu_src_a = 1; end
         "R_WB":     begin e.reg_write = 1; e.reg_dst = 1; end
         "ADDR_LW":  begin e.alu_src_a = 1; e.alu_src_b = 2'd2; e.ext_op = 1;
                           e.alu_op = 3'd1; end
         "ADDR_SW":  begin e.alu_src_a = 1; e.alu_src_b = 2'd2; e.ext_op = 1;
                           e.alu_op = 3'd2; end
         "MEM_RD":   begin e.mem_read = 1; e.iord = 1; end
         "MEM_WB":   begin e.reg_write = 1; e.mem_to_reg = 1; end
         "MEM_WR":   begin e.mem_write = 1; e.iord = 1; end
         "BRANCH":   begin e.alu_src_a = 1; e.alu_op = 3'd3; e.pc_src = 2'd1;
                           e.pc_en = az; end
         "JUMP":     begin e.alu_op = 3'd4; e.pc_src = 2'd2; e.pc_en = 1; end
         "TRAP":     begin e.illegal = 1; end
         default:    begin end
      endcase
      e.busy = !(ph == "RESET" || ph == "TRAP");
      return e;
   endfunction

   // Runs one instruction: f_st stall cycles in FETCH, m_st stall cycles in
   // the data-memory phase. With abort set, reset is asserted mid-cycle in the
   // first data-memory cycle and the instruction is abandoned there.
   task automatic exec_instr(input logic [3:0] op, input int f_st, input int m_st,
                             input logic az, input bit abort, input string tag);
      string ph[$];
      ctrl_t exp;
      ph.push_back("FETCH");
      ph.push_back("DECODE");
      case (op)
         4'd0: begin ph.push_back("EXEC_R"); ph.push_back("R_WB"); end
         4'd1: begin ph.push_back("ADDR_LW"); ph.push_back("MEM_RD"); ph.push_back("MEM_WB"); end
         4'd2: begin ph.push_back("ADDR_SW"); ph.push_back("MEM_WR"); end
         4'd3: ph.push_back("BRANCH");
         4'd4: ph.push_back("JUMP");
         default: for (int k = 0; k < 10; k++) ph.push_back("TRAP");
      endcase
      foreach (ph[i]) begin
         bit is_dmem;
         bit is_mem;
         int left;
         is_dmem = (ph[i] == "MEM_RD") || (ph[i] == "MEM_WR");
         is_mem  = is_dmem || (ph[i] == "FETCH");
         left    = (ph[i] == "FETCH") ? f_st : (is_dmem ? m_st : 0);
         forever begin
            @(negedge clk);
            mem_ready = is_mem ? (left == 0) : 1'($urandom);
            opcode    = (ph[i] == "DECODE") ? op : 4'($urandom);
            alu_zero  = (ph[i] == "BRANCH") ? az : 1'($urandom);
            #1;
            exp = expect_ctrl(ph[i], mem_ready, alu_zero);
            n_checks++;
            if (act !== exp) begin
               n_errors++;
               $display("FAIL %s phase=%s cyc=%0d got=%h exp=%h", tag, ph[i], cyc, act, exp);
            end
            n_checks++;
            if (o_mem_read && o_mem_write) begin
               n_errors++;
               $display("FAIL %s rd_wr_excl cyc=%0d got=11 exp=not both", tag, cyc);
            end
            if (abort && is_dmem) begin
               #2 rst_n = 1'b0;
               #1;
               n_checks++;
               if (act !== ctrl_t'(0)) begin
                  n_errors++;
                  $display("FAIL %s abort_outputs cyc=%0d got=%h exp=%h", tag, cyc, act, ctrl_t'(0));
               end
               return;
            end
            if (is_mem && left > 0) left--;
            else break;
         end
      end
   endtask

   // Holds reset for n cycles, then releases it; checks outputs stay idle
   // while in reset and in the RESET cycle that follows release.
   task automatic apply_reset(input int n, input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         opcode = 4'($urandom); mem_ready = 1'($urandom); alu_zero = 1'($urandom);
         #1;
         n_checks++;
         if (act !== ctrl_t'(0)) begin
            n_errors++;
            $display("FAIL %s in_reset cyc=%0d got=%h exp=%h", tag, cyc, act, ctrl_t'(0));
         end
         @(negedge clk);
      end
      rst_n = 1'b1;
      opcode = 4'($urandom); mem_ready = 1'b1; alu_zero = 1'($urandom);
      #1;
      n_checks++;
      if (act !== ctrl_t'(0)) begin
         n_errors++;
         $display("FAIL %s reset_exit cyc=%0d got=%h exp=%h", tag, cyc, act, ctrl_t'(0));
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      apply_reset(3, "reset");
      exec_instr(4'd0, 0, 0, 1'b0, 1'b0, "reset_rtype");
   endtask

   task automatic test_lw_stall();
      exec_instr(4'd1, 0, 2, 1'b0, 1'b0, "lw_stall");
      exec_instr(4'd1, 2, 0, 1'b0, 1'b0, "lw_fetch_stall");
   endtask

   task automatic test_sw();
      exec_instr(4'd2, 0, 0, 1'b0, 1'b0, "sw");
      exec_instr(4'd2, 1, 3, 1'b0, 1'b0, "sw_stall");
   endtask

   task automatic test_beq();
      exec_instr(4'd3, 0, 0, 1'b1, 1'b0, "beq_taken");
      exec_instr(4'd3, 0, 0, 1'b0, 1'b0, "beq_not_taken");
   endtask

   task automatic test_jump();
      exec_instr(4'd4, 0, 0, 1'b0, 1'b0, "jump");
   endtask

   task automatic test_trap();
      exec_instr(4'hF, 0, 0, 1'b0, 1'b0, "trap");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (o_illegal !== 1'b0 || o_busy !== 1'b0) begin
         n_errors++;
         $display("FAIL trap_async_clear illegal=%b busy=%b exp illegal=0 busy=0", o_illegal, o_busy);
      end
      apply_reset(2, "trap_reset");
      exec_instr(4'd0, 0, 0, 1'b0, 1'b0, "after_trap");
   endtask

   task automatic test_abort_mem_wr();
      exec_instr(4'd2, 0, 2, 1'b0, 1'b1, "abort_sw");
      apply_reset(1, "abort_reset");
      exec_instr(4'd1, 0, 2, 1'b0, 1'b1, "abort_lw");
      apply_reset(1, "abort_reset2");
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 40; n++) begin
         logic [3:0] op;
         int r;
         r  = $urandom_range(0, 19);
         op = (r < 18) ? 4'(r % 5) : 4'($urandom_range(5, 15));
         exec_instr(op, $urandom_range(0, 2), $urandom_range(0, 2),
                    1'($urandom), 1'b0, "random");
         if (op > 4'd4) apply_reset(1, "random_trap_reset");
      end
   endtask

   initial begin
      test_reset();
      test_lw_stall();
      test_sw();
      test_beq();
      test_jump();
      test_trap();
      test_abort_mem_wr();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Parametrised successor to the single-cycle opcode decoder.
- Sequences each instruction over multiple clock cycles: fetch, decode, execute, memory, writeback.
- Drives datapath enables and mux selects from a registered state. Stalls on a memory-ready handshake and traps undefined opcodes.
- Sits between the instruction register's opcode field and the shared-memory multicycle datapath.

Parameters:
- OP_W, 4, opcode width in bits.
- ALU_OP_W, 3, width of alu_op.
- OP_R, 0, R-type opcode.
- OP_LW, 1, load-word opcode.
- OP_SW, 2, store-word opcode.
- OP_BEQ, 3, branch-if-equal opcode.
- OP_J, 4, jump opcode.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OP_W  opcode field from the IR. Valid from DECODE onward.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- alu_zero  in  1  ALU zero flag.
- pc_en  out  1  PC load enable.
- ir_write  out  1  IR load enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALU out.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback select: 1 = MDR.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 0 = rt, 1 = const 1, 2 = ext imm, 3 = ext imm for branch.
- ext_op  out  1  immediate extension: 1 = sign, 0 = zero.
- alu_op  out  ALU_OP_W  ALU operation class. Encodings match the single-cycle unit: 0 R, 1 lw, 2 sw, 3 beq, 4 j.
- pc_src  out  2  next-PC select: 0 = ALU, 1 = ALU out register, 2 = jump target.
- illegal  out  1  sticky undefined-opcode flag.
- busy  out  1  high in every state except RESET and TRAP.

Behaviour:

Reset
- rst_n low forces state RESET immediately (asynchronous).
- Every output is 0 during and after reset until RESET is left. illegal clears.
- Deassertion is sampled on clk. RESET always goes to FETCH on the next edge.

State machine
- States: RESET, FETCH, DECODE, EXEC_R, R_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, TRAP.
- Registered state. Outputs are a combinational function of state, plus mem_ready and alu_zero where stated. No output depends on opcode except in DECODE.

Per-state outputs and transitions
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - ir_write=pc_en=mem_ready.
  - Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, ext_op=1 (branch target precompute).
  - Next state by opcode: OP_R→EXEC_R, OP_LW/OP_SW→MEM_ADDR, OP_BEQ→BRANCH, OP_J→JUMP, any other→TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=0 → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ext_op=1.
  - alu_op=1 for lw, 2 for sw.
  - Next state: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Holds while mem_ready=0; otherwise → MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEM_WR: mem_write=1, iord=1. Holds while mem_ready=0; otherwise → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=3, pc_src=1, pc_en=alu_zero → FETCH.
- JUMP: alu_op=4, pc_src=2, pc_en=1 → FETCH.
- TRAP: illegal=1, all enables 0. Remains in TRAP until reset.

Latency with mem_ready tied high
- R-type 4 cycles, lw 5, sw 4, beq 3, j 3.
- Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.

Boundary conditions
- mem_read and mem_write are never high together.
- reg_write and pc_en are never asserted in a stall cycle.
- Opcode changes outside DECODE have no effect.
- Reset asserted mid-instruction aborts with no partial write. Outputs go to 0 in the same cycle.

Test Plan:
- Reset with opcode=0, mem_ready=1, release → RESET, then FETCH, DECODE, EXEC_R, R_WB. reg_write=1 and reg_dst=1 only in cycle 4. All outputs 0 during reset.
- lw (opcode=1) with mem_ready low for 2 cycles in MEM_RD → MEM_RD held 3 cycles. mem_read=1, iord=1 throughout. MEM_WB asserts reg_write=1, mem_to_reg=1. Total 7 cycles.
- sw (opcode=2) → MEM_WR asserts mem_write=1 and alu_op=2 in MEM_ADDR. reg_write stays 0. Back to FETCH after 4 cycles.
- beq (opcode=3): alu_zero=1 → pc_en=1, pc_src=1 in BRANCH. Repeat with alu_zero=0 → pc_en=0 in BRANCH. Both take 3 cycles.
- j (opcode=4) → JUMP state: pc_src=2, pc_en=1, alu_op=4. Back to FETCH after 3 cycles.
- opcode=4'hF → TRAP after DECODE: illegal=1, busy=0, no enables. Holds 10 cycles. rst_n low clears illegal asynchronously. Also assert rst_n low during MEM_WR → mem_write drops in the same cycle.
